// File: rtl/disp_bcd_sequencer.sv
// Binary-to-BCD sequencer with a serial double-dabble engine and an 8-digit scan multiplexer.
// Optional leading-zero blanking is built when LEADING_ZERO_BLANK_EN is defined.
module disp_bcd_sequencer #(
    parameter int SCAN_DIV_W = 15,
    parameter int DATA_W     = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              busy,
    output logic              ovf,
    output logic [7:0]        digit_sel,
    output logic [3:0]        digit_val,
    output logic              digit_blank
);

    localparam int                CNT_W     = SCAN_DIV_W + 3;
    localparam logic [DATA_W-1:0] MAX_VAL   = DATA_W'(99_999_999);
    localparam logic [4:0]        LAST_ITER = 5'(DATA_W);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t               state, state_nxt;
    logic [DATA_W+31:0]   sh;
    logic [DATA_W+31:0]   sh_shift;
    logic [31:0]          bcd_adj;
    logic [31:0]          disp;
    logic [4:0]           iter;
    logic                 ovf_pend;
    logic                 accept;
    logic                 over;
    logic [CNT_W-1:0]     scan_cnt;
    logic [2:0]           idx;

    assign data_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = data_valid & data_ready;
    assign over       = (data_in > MAX_VAL);
    assign idx        = scan_cnt[CNT_W-1 -: 3];

    // NOTE: combinational blocks assign a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CONV;
            CONV:    if (iter == LAST_ITER) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every nibble that will reach 10 or more after the shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 8; i++) begin
            bcd_adj[4*i +: 4] = (sh[DATA_W + 4*i +: 4] >= 4'd5) ? sh[DATA_W + 4*i +: 4] + 4'd3
                                                                 : sh[DATA_W + 4*i +: 4];
        end
    end

    assign sh_shift = {bcd_adj, sh[DATA_W-1:0]} << 1;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // The display and ovf load together on the edge that enters COMMIT, so a partial result never shows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh       <= '0;
            iter     <= '0;
            ovf_pend <= 1'b0;
            disp     <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh       <= {32'd0, (over ? MAX_VAL : data_in)};
                        ovf_pend <= over;
                        iter     <= '0;
                    end
                end
                CONV: begin
                    if (iter != LAST_ITER) begin
                        sh   <= sh_shift;
                        iter <= iter + 5'd1;
                    end else begin
                        disp <= sh[DATA_W+31:DATA_W];
                        ovf  <= ovf_pend;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] blank_vec;

    // A digit is blank when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        blank_vec = '0;
        for (int i = 1; i < 8; i++) begin
            blank_vec[i] = ((disp >> (4*i)) == 32'd0);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt    <= '0;
            digit_sel   <= 8'h01;
            digit_val   <= 4'd0;
            digit_blank <= 1'b0;
        end else begin
            scan_cnt  <= scan_cnt + CNT_W'(1);
            digit_sel <= 8'(1) << idx;
            digit_val <= disp[4*idx +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            digit_blank <= blank_vec[idx];
`else
            digit_blank <= 1'b0;
`endif
        end
    end

endmodule
